// File: rtl/prog_fetch_pkg.sv
// -----------------------------------------------------------------------------
// prog_fetch_pkg
//   Shared types and constants for the program-memory fetch responder.
//   fetch_state_t   : fetch FSM encoding
//   NOP_OPCODE      : op_code value presented after reset
//   DATA_WORD_BYTES : bytes per data-segment entry
// -----------------------------------------------------------------------------
package prog_fetch_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_I0,
      S_I1,
      S_I2,
      S_D0,
      S_D1,
      S_D2,
      S_D3,
      S_DRAIN
   } fetch_state_t;

   localparam logic [7:0] NOP_OPCODE      = 8'h00;
   localparam int         DATA_WORD_BYTES = 4;

endpackage

// File: rtl/prog_fetch_ram.sv
// -----------------------------------------------------------------------------
// byte_ram
//   Single-port byte-wide RAM with a registered read port.
//   clk     : clock
//   i_we    : write strobe; mem[i_addr] <= i_wdata
//   i_addr  : byte address (read and write share it)
//   i_wdata : write byte
//   o_rdata : mem[i_addr] from the previous cycle
// -----------------------------------------------------------------------------
module byte_ram #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [7:0]        i_wdata,
   output logic [7:0]        o_rdata
);

   logic [7:0] r_mem [0:(1<<ADDR_W)-1];
   logic [7:0] r_rdata;

   // NOTE: the array has no reset; clearing it would turn the RAM into flops
   // and the loader is the only thing that defines its contents anyway.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/prog_fetch.sv
// -----------------------------------------------------------------------------
// prog_fetch
//   Program-memory responder for the cpu fetch interface. Keeps op_code/arg1/
//   arg2 (3 bytes at program_counter) and dataparams (big-endian word at
//   DATA_BASE + 4*dataindex) in step with the cpu, refetching when either
//   address moves away from the one last committed.
//   clk, rst                 : clock, synchronous active-high reset
//   program_counter          : instruction byte address from the cpu
//   dataindex                : data-segment entry index from the cpu
//   op_code, arg1, arg2      : committed instruction bytes
//   dataparams               : committed data word ([31:24] = lowest address)
//   insn_valid, data_valid   : committed values match the current addresses
//   load_en, load_we         : loader owns RAM / loader byte write strobe
//   load_addr, load_data     : loader byte address and data
// -----------------------------------------------------------------------------
module prog_fetch
   import prog_fetch_pkg::*;
#(
   parameter int          ADDR_W    = 16,
   parameter logic [15:0] DATA_BASE = 16'h8000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [15:0]                    program_counter,
   input  logic [15:0]                    dataindex,
   output logic [7:0]                     op_code,
   output logic [7:0]                     arg1,
   output logic [7:0]                     arg2,
   output logic [8*DATA_WORD_BYTES-1:0]   dataparams,
   output logic                           insn_valid,
   output logic                           data_valid,
   input  logic                           load_en,
   input  logic                           load_we,
   input  logic [ADDR_W-1:0]              load_addr,
   input  logic [7:0]                     load_data
);

   fetch_state_t r_state;
   fetch_state_t w_next;

   logic [15:0]      r_fetch_pc;     // pc sampled when the instruction fetch started
   logic [15:0]      r_fetch_idx;    // dataindex sampled when the data fetch started
   logic [15:0]      r_cmt_pc;
   logic [15:0]      r_cmt_idx;
   logic             r_insn_ok;      // committed instruction bytes are meaningful
   logic             r_data_ok;
   logic [2:0][7:0]  r_stage;        // bytes 0..2 of the fetch in flight

   logic [7:0]                   r_op_code;
   logic [7:0]                   r_arg1;
   logic [7:0]                   r_arg2;
   logic [8*DATA_WORD_BYTES-1:0] r_dataparams;

   logic [ADDR_W-1:0] w_ram_addr;
   logic [7:0]        w_rdata;
   logic              w_insn_stale;
   logic              w_data_stale;
   logic              w_pc_moved;
   logic              w_idx_moved;
   logic              w_dispatch;
   logic              w_start_insn;
   logic              w_start_data;
   logic              w_commit_insn;
   logic              w_commit_data;

   function automatic logic [ADDR_W-1:0] insn_addr(input logic [15:0] pc, input logic [1:0] k);
      return ADDR_W'(pc) + ADDR_W'(k);
   endfunction

   function automatic logic [ADDR_W-1:0] data_addr(input logic [15:0] idx, input logic [1:0] k);
      return ADDR_W'(DATA_BASE) + ADDR_W'({idx, 2'b00}) + ADDR_W'(k);
   endfunction

   byte_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .i_we    (load_en & load_we),
      .i_addr  (w_ram_addr),
      .i_wdata (load_data),
      .o_rdata (w_rdata)
   );

   // Loading invalidates everything immediately so the cpu never sees a
   // value that the loader may be overwriting.
   assign w_insn_stale = load_en | ~r_insn_ok | (program_counter != r_cmt_pc);
   assign w_data_stale = load_en | ~r_data_ok | (dataindex != r_cmt_idx);
   assign w_pc_moved   = program_counter != r_fetch_pc;
   assign w_idx_moved  = dataindex != r_fetch_idx;

   // Each read is presented on the RAM port in the cycle that enters its
   // state, so in Ik/Dk the RAM output already holds byte k. The last byte is
   // therefore captured straight from the RAM in I2/D3 and committed there;
   // S_DRAIN is never entered and only routes an illegal encoding home.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path can
      // leave one unassigned and infer a latch.
      w_next        = r_state;
      w_ram_addr    = '0;
      w_dispatch    = 1'b0;
      w_start_insn  = 1'b0;
      w_start_data  = 1'b0;
      w_commit_insn = 1'b0;
      w_commit_data = 1'b0;

      case (r_state)
         S_IDLE: w_dispatch = 1'b1;
         S_I0: begin
            if (w_pc_moved) w_dispatch = 1'b1;
            else begin
               w_next     = S_I1;
               w_ram_addr = insn_addr(r_fetch_pc, 2'd1);
            end
         end
         S_I1: begin
            if (w_pc_moved) w_dispatch = 1'b1;
            else begin
               w_next     = S_I2;
               w_ram_addr = insn_addr(r_fetch_pc, 2'd2);
            end
         end
         S_I2: begin
            if (w_pc_moved) w_dispatch = 1'b1;
            else begin
               w_commit_insn = 1'b1;
               w_next        = S_IDLE;
            end
         end
         // Any instruction staleness pre-empts a data fetch in progress.
         S_D0: begin
            if (w_insn_stale || w_idx_moved) w_dispatch = 1'b1;
            else begin
               w_next     = S_D1;
               w_ram_addr = data_addr(r_fetch_idx, 2'd1);
            end
         end
         S_D1: begin
            if (w_insn_stale || w_idx_moved) w_dispatch = 1'b1;
            else begin
               w_next     = S_D2;
               w_ram_addr = data_addr(r_fetch_idx, 2'd2);
            end
         end
         S_D2: begin
            if (w_insn_stale || w_idx_moved) w_dispatch = 1'b1;
            else begin
               w_next     = S_D3;
               w_ram_addr = data_addr(r_fetch_idx, 2'd3);
            end
         end
         S_D3: begin
            if (w_insn_stale || w_idx_moved) w_dispatch = 1'b1;
            else begin
               w_commit_data = 1'b1;
               w_next        = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase

      // Start (or restart) a fetch from the live addresses; instruction first.
      if (w_dispatch) begin
         if (w_insn_stale) begin
            w_next       = S_I0;
            w_ram_addr   = insn_addr(program_counter, 2'd0);
            w_start_insn = 1'b1;
         end else if (w_data_stale) begin
            w_next       = S_D0;
            w_ram_addr   = data_addr(dataindex, 2'd0);
            w_start_data = 1'b1;
         end else begin
            w_next = S_IDLE;
         end
      end

      if (load_en) begin
         w_next        = S_IDLE;
         w_ram_addr    = load_addr;
         w_start_insn  = 1'b0;
         w_start_data  = 1'b0;
         w_commit_insn = 1'b0;
         w_commit_data = 1'b0;
      end
   end

   // NOTE: all state below uses non-blocking assignment so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_fetch_pc   <= '0;
         r_fetch_idx  <= '0;
         r_cmt_pc     <= '0;
         r_cmt_idx    <= '0;
         r_insn_ok    <= 1'b0;
         r_data_ok    <= 1'b0;
         r_stage      <= '0;
         r_op_code    <= NOP_OPCODE;
         r_arg1       <= 8'h00;
         r_arg2       <= 8'h00;
         r_dataparams <= '0;
      end else begin
         r_state <= w_next;
         if (load_en) begin
            r_insn_ok <= 1'b0;
            r_data_ok <= 1'b0;
         end
         if (w_start_insn) r_fetch_pc  <= program_counter;
         if (w_start_data) r_fetch_idx <= dataindex;

         // Staging may collect bytes of a fetch that is later dropped; it
         // only reaches the outputs through a commit.
         case (r_state)
            S_I0, S_D0: r_stage[0] <= w_rdata;
            S_I1, S_D1: r_stage[1] <= w_rdata;
            S_D2:       r_stage[2] <= w_rdata;
            default:    ;
         endcase

         if (w_commit_insn) begin
            r_op_code <= r_stage[0];
            r_arg1    <= r_stage[1];
            r_arg2    <= w_rdata;
            r_cmt_pc  <= r_fetch_pc;
            r_insn_ok <= 1'b1;
         end
         if (w_commit_data) begin
            r_dataparams <= {r_stage[0], r_stage[1], r_stage[2], w_rdata};
            r_cmt_idx    <= r_fetch_idx;
            r_data_ok    <= 1'b1;
         end
      end
   end

   assign op_code    = r_op_code;
   assign arg1       = r_arg1;
   assign arg2       = r_arg2;
   assign dataparams = r_dataparams;
   assign insn_valid = ~w_insn_stale;
   assign data_valid = ~w_data_stale;

endmodule

// File: tb/tb_prog_fetch.sv
// -----------------------------------------------------------------------------
// tb_prog_fetch
//   Self-checking bench for prog_fetch: a byte-array model of the program RAM
//   gives the expected instruction bytes and data word, a scoreboard queue
//   holds each expectation until the DUT settles, and latencies are counted
//   in clock edges from the stimulus change.
// -----------------------------------------------------------------------------
module tb_prog_fetch;

   logic        clk;
   logic        rst;
   logic [15:0] program_counter;
   logic [15:0] dataindex;
   logic [7:0]  op_code;
   logic [7:0]  arg1;
   logic [7:0]  arg2;
   logic [31:0] dataparams;
   logic        insn_valid;
   logic        data_valid;
   logic        load_en;
   logic        load_we;
   logic [15:0] load_addr;
   logic [7:0]  load_data;

   prog_fetch dut (
      .clk             (clk),
      .rst             (rst),
      .program_counter (program_counter),
      .dataindex       (dataindex),
      .op_code         (op_code),
      .arg1            (arg1),
      .arg2            (arg2),
      .dataparams      (dataparams),
      .insn_valid      (insn_valid),
      .data_valid      (data_valid),
      .load_en         (load_en),
      .load_we         (load_we),
      .load_addr       (load_addr),
      .load_data       (load_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
   } preload_t;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] idx;
      int          li;
      int          ld;
   } vec_t;

   typedef struct {
      string       name;
      logic [23:0] insn;
      logic [31:0] data;
      int          li;
      int          ld;
   } exp_t;

   logic [7:0]  mem_model [0:65535];
   exp_t        sb [$];
   logic [23:0] old_insn;
   logic [31:0] old_data;
   int          n_tests;
   int          n_fail;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_byte(input logic [15:0] a, input logic [7:0] d);
      load_en   = 1'b1;
      load_we   = 1'b1;
      load_addr = a;
      load_data = d;
      mem_model[a] = d;
      step();
      load_we = 1'b0;
   endtask

   function automatic logic [23:0] exp_insn(input logic [15:0] pc);
      logic [15:0] a1;
      logic [15:0] a2;
      a1 = pc + 16'd1;
      a2 = pc + 16'd2;
      return {mem_model[pc], mem_model[a1], mem_model[a2]};
   endfunction

   function automatic logic [31:0] exp_data(input logic [15:0] idx);
      logic [15:0] b;
      logic [31:0] w;
      b = 16'h8000 + (idx << 2);
      for (int k = 0; k < 4; k++) begin
         logic [15:0] a;
         a = b + 16'(k);
         w = {w[23:0], mem_model[a]};
      end
      return w;
   endfunction

   // Counts edges until each valid rises; meanwhile every sample of the
   // outputs must be either the previous committed value or the new one.
   task automatic measure(input logic [23:0] o_i, input logic [23:0] n_i,
                          input logic [31:0] o_d, input logic [31:0] n_d,
                          output int li, output int ld, output int bad);
      li  = -1;
      ld  = -1;
      bad = 0;
      #1;
      for (int n = 0; n <= 40; n++) begin
         if ({op_code, arg1, arg2} !== o_i && {op_code, arg1, arg2} !== n_i) bad++;
         if (dataparams !== o_d && dataparams !== n_d) bad++;
         if (li < 0 && insn_valid) li = n;
         if (ld < 0 && data_valid) ld = n;
         if (li >= 0 && ld >= 0) break;
         step();
      end
   endtask

   task automatic expect_settle(input string name, input int li, input int ld);
      exp_t e;
      exp_t got;
      int   m_li;
      int   m_ld;
      int   bad;
      e.name = name;
      e.insn = exp_insn(program_counter);
      e.data = exp_data(dataindex);
      e.li   = li;
      e.ld   = ld;
      sb.push_back(e);
      measure(old_insn, e.insn, old_data, e.data, m_li, m_ld, bad);
      got = sb.pop_front();
      check({got.name, "/insn_latency"}, m_li, got.li);
      check({got.name, "/data_latency"}, m_ld, got.ld);
      check({got.name, "/insn_bytes"}, {8'h00, op_code, arg1, arg2}, {8'h00, got.insn});
      check({got.name, "/dataparams"}, dataparams, got.data);
      check({got.name, "/no_mixed"}, bad, 0);
      old_insn = got.insn;
      old_data = got.data;
   endtask

   preload_t pre [20];
   vec_t     vecs [6];

   initial begin
      n_tests = 0;
      n_fail  = 0;
      pre = '{
         '{16'h0000, 8'h10}, '{16'h0001, 8'h05}, '{16'h0002, 8'h07},
         '{16'h0003, 8'h21}, '{16'h0004, 8'h22}, '{16'h0005, 8'h23},
         '{16'h0010, 8'hA1}, '{16'h0011, 8'hA2}, '{16'h0012, 8'hA3},
         '{16'hFFFE, 8'hB8}, '{16'hFFFF, 8'h00},
         '{16'h8000, 8'hDE}, '{16'h8001, 8'hAD}, '{16'h8002, 8'hBE}, '{16'h8003, 8'hEF},
         '{16'h8004, 8'h01}, '{16'h8005, 8'h02}, '{16'h8006, 8'h03}, '{16'h8007, 8'h04},
         '{16'h7FFC, 8'h11}
      };
      vecs = '{
         '{16'h0010, 16'h0000, 4, 0},
         '{16'h0010, 16'h0001, 0, 5},
         '{16'h0003, 16'h7FFF, 4, 9},
         '{16'hFFFE, 16'h0001, 4, 9},
         '{16'h0000, 16'h0001, 4, 0},
         '{16'h0000, 16'h0000, 0, 5}
      };

      rst             = 1'b1;
      program_counter = 16'h0000;
      dataindex       = 16'h0000;
      load_en         = 1'b0;
      load_we         = 1'b0;
      load_addr       = 16'h0000;
      load_data       = 8'h00;
      step();

      // Preload while held in reset.
      foreach (pre[i]) load_byte(pre[i].addr, pre[i].data);
      load_byte(16'h7FFD, 8'h22);
      load_byte(16'h7FFE, 8'h33);
      load_byte(16'h7FFF, 8'h44);
      load_en = 1'b0;
      step();
      check("reset/insn_bytes", {8'h00, op_code, arg1, arg2}, 32'h0);
      check("reset/dataparams", dataparams, 32'h0);
      check("reset/insn_valid", insn_valid, 1'b0);
      check("reset/data_valid", data_valid, 1'b0);

      // Release reset with pc=0, dataindex=0.
      old_insn = 24'h0;
      old_data = 32'h0;
      rst = 1'b0;
      expect_settle("reset_fetch", 4, 9);

      // Wrap case needs mem[0]=02; reloading also exercises the refetch.
      load_byte(16'h0000, 8'h02);
      load_en = 1'b0;
      expect_settle("reload", 4, 9);

      foreach (vecs[i]) begin
         program_counter = vecs[i].pc;
         dataindex       = vecs[i].idx;
         expect_settle($sformatf("vec%0d", i), vecs[i].li, vecs[i].ld);
      end

      // pc moves 0 -> 0x10, then to 3 two cycles into the fetch.
      program_counter = 16'h0010;
      step();
      step();
      check("restart/valid_low_mid_fetch", insn_valid, 1'b0);
      program_counter = 16'h0003;
      expect_settle("restart", 4, 0);

      // pc leaves and returns to the committed value mid-fetch.
      program_counter = 16'h0010;
      step();
      program_counter = 16'h0003;
      #1;
      check("return/valid_immediate", insn_valid, 1'b1);
      for (int k = 0; k < 5; k++) step();
      expect_settle("return", 0, 0);

      // pc change during a data fetch: instruction served first, then data.
      dataindex = 16'h0001;
      step();
      step();
      program_counter = 16'h0010;
      expect_settle("pc_during_data", 4, 9);

      // Load mid-fetch.
      program_counter = 16'h0003;
      step();
      load_byte(16'h0000, 8'hAC);
      check("load/insn_valid_low", insn_valid, 1'b0);
      check("load/data_valid_low", data_valid, 1'b0);
      step();
      check("load/held_insn_bytes", {8'h00, op_code, arg1, arg2}, {8'h00, old_insn});
      program_counter = 16'h0000;
      load_en = 1'b0;
      expect_settle("after_load", 4, 9);

      // Reset mid-fetch.
      program_counter = 16'h0010;
      step();
      step();
      rst = 1'b1;
      step();
      check("reset_mid/insn_bytes", {8'h00, op_code, arg1, arg2}, 32'h0);
      check("reset_mid/dataparams", dataparams, 32'h0);
      check("reset_mid/insn_valid", insn_valid, 1'b0);
      check("reset_mid/data_valid", data_valid, 1'b0);
      old_insn = 24'h0;
      old_data = 32'h0;
      rst = 1'b0;
      expect_settle("reset_mid_refetch", 4, 9);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
